// File: rtl/sqrt_table_loader.sv
// Runtime loader for the fsqrt seed table: assembles 36-bit entries from a
// 5-byte MSB-first stream, writes them sequentially into a DEPTH x DW RAM and
// serves a registered 1-cycle read port with the same timing as the table ROM.
module sqrt_table_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 36
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          loaded,
  output logic          err,
  output logic [AW:0]   wr_count,
  input  logic [AW-1:0] index,
  output logic [DW-1:0] o_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e        state_q, state_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    hi_q, hi_d;
  logic [23:0]   lo_q, lo_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic          accept;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem_q [DEPTH];

  assign accept  = in_valid && (state_q == StLoad);
  // Last byte goes straight into the write word; no extra register stage.
  assign wr_data = DW'({hi_q, lo_q, in_data});

  // Status outputs are pure state decodes so reset clears them immediately.
  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q == StLoad);
  assign loaded   = (state_q == StDone);
  assign err      = (state_q == StErr);
  assign wr_count = wr_count_q;
  assign o_data   = rdata_q;

  // Control and assembly registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      byte_cnt_q <= 3'd0;
      hi_q       <= 4'd0;
      lo_q       <= 24'd0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next-state: start (re)enters LOAD from any non-LOAD state; in LOAD, bytes
  // are counted 0..4 and the fifth byte commits the entry.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wr_count_d = wr_count_q;
    wr_en      = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLoad;
          byte_cnt_d = 3'd0;
          wr_count_d = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (byte_cnt_q == 3'd0) begin
            // Upper nibble of the first byte is reserved; non-zero aborts the load.
            if (in_data[7:4] != 4'd0) begin
              state_d = StErr;
            end else begin
              hi_d       = in_data[3:0];
              byte_cnt_d = 3'd1;
            end
          end else if (byte_cnt_q == 3'd4) begin
            wr_en      = 1'b1;
            byte_cnt_d = 3'd0;
            wr_count_d = wr_count_q + (AW+1)'(1);
            if (wr_count_d == (AW+1)'(DEPTH)) begin
              state_d = StDone;
            end
          end else begin
            lo_d       = {lo_q[15:0], in_data};
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Table RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_count_q[AW-1:0]] <= wr_data;
    end
  end

  // Registered read, every cycle; non-blocking update gives read-before-write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[index];
    end
  end

endmodule

// File: tb/tb_sqrt_table_loader.sv
// Self-checking bench for sqrt_table_loader: randomized byte streams against a
// behavioural table model (array of expected entries and an entry counter).
module tb_sqrt_table_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 36;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          loaded;
  logic          err;
  logic [AW:0]   wr_count;
  logic [AW-1:0] index;
  logic [DW-1:0] o_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [35:0] model_mem [DEPTH];

  sqrt_table_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .loaded   (loaded),
    .err      (err),
    .wr_count (wr_count),
    .index    (index),
    .o_data   (o_data)
  );

  always #5 clk = ~clk;

  // Byte i (0..4) of an entry in stream order.
  function automatic logic [7:0] byte_of(input logic [35:0] e, input int i);
    if (i == 0) return {4'h0, e[35:32]};
    return e[39-8*i -: 8];
  endfunction

  function automatic logic [35:0] rand_entry();
    logic [3:0]  h;
    logic [31:0] l;
    h = 4'($urandom_range(0, 15));
    l = $urandom();
    return {h, l};
  endfunction

  // Optional idle cycles (junk data, valid low), then one valid cycle.
  task automatic send_byte(input logic [7:0] b, input logic st, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom());
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_entry(input logic [35:0] e);
    for (int i = 0; i < 5; i++) send_byte(byte_of(e, i), 1'b0, 0);
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_read(input int idx, output logic [35:0] d);
    index = AW'(idx);
    @(posedge clk); #1;
    d = o_data;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h0; index = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, busy, loaded, err} !== 4'b0 || wr_count !== '0 || o_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy/busy/ld/err=%b wr_count=%0d o_data=%h, required all 0",
               {in_ready, busy, loaded, err}, wr_count, o_data);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: in_ready=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_full_load();
    int rdy = 0;
    logic [35:0] d;
    do_start();
    for (int c = 0; c < 5 * DEPTH; c++) begin
      in_valid = 1'b1;
      in_data  = byte_of(36'(c / 5), c % 5);
      if (in_ready === 1'b1) rdy++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 36'(k);
    n_vec++;
    if (rdy != 5 * DEPTH || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready_cycles: got %0d then in_ready=%b, required 5120 then 0",
               rdy, in_ready);
    end
    n_vec++;
    if (loaded !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || wr_count !== 11'd1024) begin
      n_err++;
      $display("FAIL full_status: loaded=%b busy=%b err=%b wr_count=%0d, required 1 0 0 1024",
               loaded, busy, err, wr_count);
    end
    do_read(37, d);
    n_vec++;
    if (d !== 36'd37) begin
      n_err++;
      $display("FAIL full_read37: o_data=%h, required %h", d, 36'd37);
    end
  endtask

  task automatic test_gaps();
    logic [35:0] e, d;
    int gap;
    do_start();
    for (int k = 0; k < DEPTH; k++) begin
      e = (k == 0) ? 36'hF_FFFF_FFFF : rand_entry();
      for (int i = 0; i < 5; i++) begin
        gap = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2)) : 0;
        send_byte(byte_of(e, i), 1'b0, gap);
        n_vec++;
        if (wr_count !== 11'(k + ((i == 4) ? 1 : 0))) begin
          n_err++;
          $display("FAIL gaps_wr_count: entry %0d byte %0d wr_count=%0d, required %0d",
                   k, i, wr_count, k + ((i == 4) ? 1 : 0));
        end
      end
      model_mem[k] = e;
    end
    n_vec++;
    if (loaded !== 1'b1) begin
      n_err++;
      $display("FAIL gaps_loaded: loaded=%b, required 1", loaded);
    end
    for (int k = 0; k < DEPTH; k++) begin
      do_read(k, d);
      n_vec++;
      if (d !== model_mem[k]) begin
        n_err++;
        $display("FAIL gaps_readback: index %0d o_data=%h, required %h", k, d, model_mem[k]);
      end
    end
  endtask

  task automatic test_error();
    logic [35:0] e, d;
    do_start();
    for (int k = 0; k < 3; k++) begin
      e = rand_entry();
      send_entry(e);
      model_mem[k] = e;
    end
    send_byte(8'h10, 1'b0, 0);
    n_vec++;
    if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || wr_count !== 11'd3) begin
      n_err++;
      $display("FAIL err_entry: err=%b in_ready=%b busy=%b wr_count=%0d, required 1 0 0 3",
               err, in_ready, busy, wr_count);
    end
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 15)), 1'b0, 0);
    n_vec++;
    if (err !== 1'b1 || wr_count !== 11'd3) begin
      n_err++;
      $display("FAIL err_sticky: err=%b wr_count=%0d, required 1 3", err, wr_count);
    end
    do_read(3, d);
    n_vec++;
    if (d !== model_mem[3]) begin
      n_err++;
      $display("FAIL err_ram_unchanged: o_data=%h, required %h", d, model_mem[3]);
    end
    do_start();
    n_vec++;
    if (err !== 1'b0 || wr_count !== 11'd0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL err_restart: err=%b wr_count=%0d busy=%b in_ready=%b, required 0 0 1 1",
               err, wr_count, busy, in_ready);
    end
  endtask

  // Continues the load started by test_error.
  task automatic test_collision();
    logic [35:0] e, a, b;
    for (int k = 0; k < 5; k++) begin
      e = rand_entry();
      send_entry(e);
      model_mem[k] = e;
    end
    b = model_mem[5];
    a = rand_entry();
    if (a == b) a = ~b;
    index = AW'(5);
    for (int i = 0; i < 4; i++) send_byte(byte_of(a, i), 1'b0, 0);
    send_byte(byte_of(a, 4), 1'b0, 0);
    model_mem[5] = a;
    n_vec++;
    if (o_data !== b) begin
      n_err++;
      $display("FAIL collision_old: o_data=%h, required %h", o_data, b);
    end
    @(posedge clk); #1;
    n_vec++;
    if (o_data !== a) begin
      n_err++;
      $display("FAIL collision_new: o_data=%h, required %h", o_data, a);
    end
  endtask

  // Finishes the same load with stray start pulses, including one on the last byte.
  task automatic test_start_ignored();
    logic [35:0] e, d;
    for (int k = 6; k < DEPTH; k++) begin
      e = rand_entry();
      for (int i = 0; i < 5; i++) begin
        send_byte(byte_of(e, i),
                  ((k == 100 || k == 500) && i == 2) || (k == DEPTH - 1 && i == 4), 0);
      end
      model_mem[k] = e;
      if (k == 100 || k == 500) begin
        n_vec++;
        if (wr_count !== 11'(k + 1) || busy !== 1'b1) begin
          n_err++;
          $display("FAIL start_in_load: wr_count=%0d busy=%b, required %0d 1",
                   wr_count, busy, k + 1);
        end
      end
    end
    n_vec++;
    if (loaded !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || wr_count !== 11'd1024) begin
      n_err++;
      $display("FAIL start_on_last: loaded=%b in_ready=%b busy=%b wr_count=%0d, req 1 0 0 1024",
               loaded, in_ready, busy, wr_count);
    end
    for (int j = 0; j < 8; j++) begin
      int idx = (j < 4) ? j * 100 : int'($urandom_range(0, DEPTH - 1));
      do_read(idx, d);
      n_vec++;
      if (d !== model_mem[idx]) begin
        n_err++;
        $display("FAIL second_load_read: index %0d o_data=%h, required %h",
                 idx, d, model_mem[idx]);
      end
    end
  endtask

  task automatic test_bytes_in_done();
    logic [35:0] d;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 15));
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b0 || loaded !== 1'b1 || wr_count !== 11'd1024) begin
        n_err++;
        $display("FAIL done_ignore: in_ready=%b loaded=%b wr_count=%0d, required 0 1 1024",
                 in_ready, loaded, wr_count);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_read(k, d);
      n_vec++;
      if (d !== model_mem[k]) begin
        n_err++;
        $display("FAIL done_no_write: index %0d o_data=%h, required %h", k, d, model_mem[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] e, d;
    do_start();
    for (int k = 0; k < 500; k++) begin
      e = rand_entry();
      send_entry(e);
      model_mem[k] = e;
    end
    rstn = 1'b0;
    #2;
    n_vec++;
    if ({in_ready, busy, loaded, err} !== 4'b0 || wr_count !== '0 || o_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: rdy/busy/ld/err=%b wr_count=%0d o_data=%h, required all 0",
               {in_ready, busy, loaded, err}, wr_count, o_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 15));
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b0 || wr_count !== '0) begin
        n_err++;
        $display("FAIL idle_ignore: in_ready=%b wr_count=%0d, required 0 0", in_ready, wr_count);
      end
    end
    in_valid = 1'b0;
    do_start();
    for (int k = 0; k < DEPTH; k++) begin
      e = rand_entry();
      send_entry(e);
      model_mem[k] = e;
    end
    n_vec++;
    if (loaded !== 1'b1 || wr_count !== 11'd1024) begin
      n_err++;
      $display("FAIL reload: loaded=%b wr_count=%0d, required 1 1024", loaded, wr_count);
    end
    for (int k = 0; k < DEPTH; k++) begin
      do_read(k, d);
      n_vec++;
      if (d !== model_mem[k]) begin
        n_err++;
        $display("FAIL reload_readback: index %0d o_data=%h, required %h",
                 k, d, model_mem[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gaps();
    test_error();
    test_collision();
    test_start_ignored();
    test_bytes_in_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
